// File: rtl/regfile_b64_reader_if.sv
// rtl/regfile_b64_reader_if.sv - register-file read port and Base64 character stream bundle
interface regfile_b64_reader_if #(
    parameter int AW = 3,
    parameter int DW = 6
);
    logic [AW-1:0] RD_ADDR;
    logic [DW-1:0] RD_DATA;
    logic [7:0]    CHAR_OUT;
    logic          CHAR_VALID;
    logic          CHAR_READY;

    modport master (
        output RD_ADDR,
        output CHAR_OUT,
        output CHAR_VALID,
        input  RD_DATA,
        input  CHAR_READY
    );

    modport slave (
        input  RD_ADDR,
        input  CHAR_OUT,
        input  CHAR_VALID,
        output RD_DATA,
        output CHAR_READY
    );
endinterface

// File: rtl/regfile_b64_reader.sv
// rtl/regfile_b64_reader.sv - scans register-file entries and streams their Base64 characters
// Optional '=' padding to a multiple of four characters is enabled by defining B64_PAD_EN.
module regfile_b64_reader #(
    parameter int NREGS = 8,
    parameter int AW    = 3,
    parameter int DW    = 6
) (
    input  logic                 CLK,
    input  logic                 CLRN,
    input  logic                 START,
    input  logic [3:0]           COUNT,
    output logic                 BUSY,
    output logic                 DONE,
    regfile_b64_reader_if.master bus
);
    localparam int CW = 4;
    localparam logic [CW-1:0] NMAX = CW'(NREGS);

`ifdef B64_PAD_EN
    typedef enum logic [1:0] {IDLE, FETCH, SEND, PAD} state_t;
`else
    typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;
`endif

    state_t          state_q;
    logic [AW-1:0]   rd_addr_q;
    logic [7:0]      char_q;
    logic            valid_q;
    logic            busy_q;
    logic            done_q;
    logic [CW-1:0]   n_q;
    logic [CW-1:0]   sent_q;
    logic [CW-1:0]   n_d;
    logic [CW-1:0]   sent_d;
`ifdef B64_PAD_EN
    logic [1:0]      pad_q;
`endif

    function automatic logic [7:0] b64(input logic [5:0] v);
        logic [7:0] w;
        w = {2'b00, v};
        if (v < 6'd26)      return w + 8'h41;
        else if (v < 6'd52) return w + 8'h47;
        else if (v < 6'd62) return w - 8'h04;
        else if (v == 6'd62) return 8'h2B;
        else                return 8'h2F;
    endfunction

    assign n_d    = (COUNT > NMAX) ? NMAX : COUNT;
    assign sent_d = sent_q + 4'd1;

    always_ff @(posedge CLK or negedge CLRN) begin
        if (!CLRN) begin
            state_q   <= IDLE;
            rd_addr_q <= '0;
            char_q    <= 8'h00;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            n_q       <= '0;
            sent_q    <= '0;
`ifdef B64_PAD_EN
            pad_q     <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (START) begin
                        if (COUNT != 4'd0) begin
                            n_q       <= n_d;
                            rd_addr_q <= '0;
                            sent_q    <= '0;
                            busy_q    <= 1'b1;
                            state_q   <= FETCH;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                // RD_ADDR has been stable for a full cycle, so RD_DATA is settled here.
                FETCH: begin
                    char_q  <= b64(bus.RD_DATA[5:0]);
                    valid_q <= 1'b1;
                    state_q <= SEND;
                end
                SEND: begin
                    if (bus.CHAR_READY) begin
                        sent_q  <= sent_d;
                        valid_q <= 1'b0;
                        if (sent_d < n_q) begin
                            rd_addr_q <= rd_addr_q + 1'b1;
                            state_q   <= FETCH;
                        end else begin
                            rd_addr_q <= '0;
`ifdef B64_PAD_EN
                            if (n_q[1:0] != 2'd0) begin
                                char_q  <= 8'h3D;
                                valid_q <= 1'b1;
                                pad_q   <= 2'(3'd4 - {1'b0, n_q[1:0]});
                                state_q <= PAD;
                            end else begin
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= IDLE;
                            end
`else
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
`endif
                        end
                    end
                end
`ifdef B64_PAD_EN
                // Pad characters stay valid back-to-back; only the count changes per handshake.
                PAD: begin
                    if (bus.CHAR_READY) begin
                        if (pad_q == 2'd1) begin
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            pad_q <= pad_q - 2'd1;
                        end
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.RD_ADDR    = rd_addr_q;
    assign bus.CHAR_OUT   = char_q;
    assign bus.CHAR_VALID = valid_q;
    assign BUSY           = busy_q;
    assign DONE           = done_q;
endmodule
